// File: rtl/can_fifo_pkg.sv
// Shared types and default sizing for the CAN receive FIFO.
// Info records pair a stored frame length with an overrun flag.
package can_fifo_pkg;

  localparam int DEF_DATA_AW  = 6;
  localparam int DEF_INFO_AW  = 5;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_AFULL_TH = 48;

  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
    logic                 ovr;
  } info_t;

endpackage

// File: rtl/can_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clk/rst_n, we/waddr/wdata write, raddr in, rdata registered out.
module can_sdp_ram #(
  parameter int W  = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-during-write to the same address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/can_rx_fifo_gen.sv
// CAN receive FIFO: circular byte RAM plus per-frame info RAM.
// Ports: wr/data_in/frame_end/frame_abort in, head frame + counters out.
module can_rx_fifo_gen
  import can_fifo_pkg::*;
#(
  parameter int DATA_AW  = DEF_DATA_AW,
  parameter int INFO_AW  = DEF_INFO_AW,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int AFULL_TH = DEF_AFULL_TH,
  parameter int U_DLY    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [7:0]         data_in,
  input  logic               frame_end,
  input  logic               frame_abort,
  input  logic               reset_mode,
  input  logic               release_buffer,
  input  logic [LEN_W-1:0]   rd_offset,
  output logic [7:0]         data_out,
  output logic [LEN_W-1:0]   head_len,
  output logic               head_overrun,
  output logic               info_empty,
  output logic [INFO_AW:0]   frame_cnt,
  output logic [DATA_AW:0]   byte_cnt,
  output logic               almost_full,
  output logic [7:0]         drop_cnt,
  output logic               init_busy
);

  // U_DLY only shapes behavioural models; the netlist has no delay.
  if (U_DLY < 0) begin : g_bad_dly
    $error("U_DLY must be non-negative");
  end

  localparam logic [DATA_AW:0] AF_TH =
    (DATA_AW+1)'(AFULL_TH);

  logic [DATA_AW-1:0] wr_ptr, frame_start, rd_ptr;
  logic [INFO_AW-1:0] iwr_ptr, ird_ptr, init_cnt;
  logic [LEN_W-1:0]   len, len_next;
  logic               ovr_latch, ovr_next;
  logic [LEN_W:0]     info_rdata, info_wdata;
  logic [INFO_AW-1:0] info_waddr;
  logic               info_we;

  logic act, wr_ok, wr_rej, rel, abort, fe;
  logic fe_real, commit, drop, rollback;
  logic [DATA_AW:0]   rb_sub, rel_sub;

  assign head_len     = info_rdata[LEN_W:1];
  assign head_overrun = info_rdata[0];
  assign info_empty   = (frame_cnt == '0);
  assign almost_full  = (byte_cnt >= AF_TH);

  always_comb begin
    act    = !init_busy && !reset_mode;
    wr_ok  = act && wr && !byte_cnt[DATA_AW] && !(&len);
    wr_rej = act && wr && !wr_ok;
    rel    = act && release_buffer && !info_empty;
    abort  = act && frame_abort;
    fe     = act && frame_end && !frame_abort;
    len_next = len + LEN_W'(wr_ok);
    ovr_next = ovr_latch || wr_rej;
    // The byte written alongside frame_end belongs to that frame.
    fe_real  = fe && ((len_next != '0) || ovr_next);
    commit   = fe_real && !frame_cnt[INFO_AW];
    drop     = fe_real && frame_cnt[INFO_AW];
    rollback = abort || drop;
    rb_sub   = rollback ? (DATA_AW+1)'(len_next) : '0;
    rel_sub  = rel ? (DATA_AW+1)'(head_len) : '0;
  end

  always_comb begin
    info_we    = init_busy || commit;
    info_waddr = init_busy ? init_cnt : iwr_ptr;
    info_wdata = init_busy ? '0 : {len_next, ovr_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      frame_start <= '0;
      rd_ptr      <= '0;
      iwr_ptr     <= '0;
      ird_ptr     <= '0;
      init_cnt    <= '0;
      init_busy   <= 1'b1;
      len         <= '0;
      ovr_latch   <= 1'b0;
      byte_cnt    <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      if (init_busy) begin
        init_cnt <= init_cnt + INFO_AW'(1);
        if (&init_cnt) init_busy <= 1'b0;
      end
      if (reset_mode) begin
        wr_ptr      <= rd_ptr;
        frame_start <= rd_ptr;
        iwr_ptr     <= ird_ptr;
        len         <= '0;
        ovr_latch   <= 1'b0;
        byte_cnt    <= '0;
        frame_cnt   <= '0;
      end else begin
        byte_cnt <= byte_cnt
                  + (DATA_AW+1)'(wr_ok)
                  - rb_sub - rel_sub;
        frame_cnt <= frame_cnt
                   + (INFO_AW+1)'(commit)
                   - (INFO_AW+1)'(rel);
        if (rollback)
          wr_ptr <= frame_start;
        else
          wr_ptr <= wr_ptr + DATA_AW'(wr_ok);
        if (commit) begin
          frame_start <= wr_ptr + DATA_AW'(wr_ok);
          iwr_ptr     <= iwr_ptr + INFO_AW'(1);
        end
        if (commit || rollback) begin
          len       <= '0;
          ovr_latch <= 1'b0;
        end else begin
          len       <= len_next;
          ovr_latch <= ovr_next;
        end
        if (rel) begin
          rd_ptr  <= rd_ptr + DATA_AW'(head_len);
          ird_ptr <= ird_ptr + INFO_AW'(1);
        end
        if (drop && drop_cnt != 8'hff)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  can_sdp_ram #(.W(8), .AW(DATA_AW)) u_byte_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr + DATA_AW'(rd_offset)),
    .rdata (data_out)
  );

  can_sdp_ram #(.W(LEN_W+1), .AW(INFO_AW)) u_info_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (info_we),
    .waddr (info_waddr),
    .wdata (info_wdata),
    .raddr (ird_ptr),
    .rdata (info_rdata)
  );

endmodule

// File: tb/tb_can_rx_fifo_gen.sv
// Scoreboard bench for can_rx_fifo_gen at default sizing.
// Expected frames are queued on commit and checked on read-out.
module tb_can_rx_fifo_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data_in = '0;
  logic       frame_end = 1'b0;
  logic       frame_abort = 1'b0;
  logic       reset_mode = 1'b0;
  logic       release_buffer = 1'b0;
  logic [3:0] rd_offset = '0;
  logic [7:0] data_out;
  logic [3:0] head_len;
  logic       head_overrun;
  logic       info_empty;
  logic [5:0] frame_cnt;
  logic [6:0] byte_cnt;
  logic       almost_full;
  logic [7:0] drop_cnt;
  logic       init_busy;

  can_rx_fifo_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr             (wr),
    .data_in        (data_in),
    .frame_end      (frame_end),
    .frame_abort    (frame_abort),
    .reset_mode     (reset_mode),
    .release_buffer (release_buffer),
    .rd_offset      (rd_offset),
    .data_out       (data_out),
    .head_len       (head_len),
    .head_overrun   (head_overrun),
    .info_empty     (info_empty),
    .frame_cnt      (frame_cnt),
    .byte_cnt       (byte_cnt),
    .almost_full    (almost_full),
    .drop_cnt       (drop_cnt),
    .init_busy      (init_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_bytes[$];
  logic [7:0] pend[$];
  int         exp_len[$];
  bit         exp_ovr[$];
  bit         povr = 1'b0;
  int         m_bytes = 0;
  int         m_frames = 0;
  int         m_drop = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_fcnt"}, frame_cnt, m_frames);
    chk({tag, "_bcnt"}, byte_cnt, m_bytes);
    chk({tag, "_drop"}, drop_cnt, m_drop);
    chk({tag, "_afull"}, almost_full, m_bytes >= 48);
    chk({tag, "_empty"}, info_empty, m_frames == 0);
  endtask

  task automatic model_clear(input bit all);
    exp_bytes.delete();
    pend.delete();
    exp_len.delete();
    exp_ovr.delete();
    povr = 1'b0;
    m_bytes = 0;
    m_frames = 0;
    if (all) m_drop = 0;
  endtask

  task automatic model_wr(input logic [7:0] b);
    if (m_bytes < 64 && pend.size() < 15) begin
      pend.push_back(b);
      m_bytes++;
    end else begin
      povr = 1'b1;
    end
  endtask

  task automatic model_rel();
    int n;
    if (exp_len.size() > 0) begin
      n = exp_len.pop_front();
      void'(exp_ovr.pop_front());
      repeat (n) void'(exp_bytes.pop_front());
      m_bytes -= n;
      m_frames--;
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    wr = 1'b1;
    data_in = b;
    tick();
    wr = 1'b0;
    model_wr(b);
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    if (pend.size() != 0 || povr) begin
      if (m_frames < 32) begin
        exp_len.push_back(pend.size());
        exp_ovr.push_back(povr);
        foreach (pend[i]) exp_bytes.push_back(pend[i]);
        m_frames++;
      end else begin
        m_bytes -= pend.size();
        if (m_drop < 255) m_drop++;
      end
    end
    pend.delete();
    povr = 1'b0;
    tick();
  endtask

  task automatic abort_frame();
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    m_bytes -= pend.size();
    pend.delete();
    povr = 1'b0;
  endtask

  task automatic release_head();
    release_buffer = 1'b1;
    tick();
    release_buffer = 1'b0;
    model_rel();
    tick();
  endtask

  task automatic rel_and_write(input logic [7:0] b);
    release_buffer = 1'b1;
    wr = 1'b1;
    data_in = b;
    tick();
    release_buffer = 1'b0;
    wr = 1'b0;
    model_wr(b);
    model_rel();
    tick();
  endtask

  task automatic check_head(input string tag);
    if (exp_len.size() == 0) begin
      chk({tag, "_isempty"}, info_empty, 1);
    end else begin
      chk({tag, "_hlen"}, head_len, exp_len[0]);
      chk({tag, "_hovr"}, head_overrun, exp_ovr[0]);
      for (int i = 0; i < exp_len[0]; i++) begin
        rd_offset = 4'(i);
        tick();
        tick();
        chk($sformatf("%s_b%0d", tag, i), data_out, exp_bytes[i]);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    int n;
    rst_n = 1'b0;
    wr = 1'b0;
    frame_end = 1'b0;
    frame_abort = 1'b0;
    reset_mode = 1'b0;
    release_buffer = 1'b0;
    rd_offset = '0;
    model_clear(1'b1);
    #23;
    chk({tag, "_rst_dout"}, data_out, 0);
    chk({tag, "_rst_hlen"}, head_len, 0);
    chk({tag, "_rst_hovr"}, head_overrun, 0);
    chk({tag, "_rst_busy"}, init_busy, 1);
    chk_counts({tag, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
    // Writes and frame ends offered during init must be ignored.
    wr = 1'b1;
    data_in = 8'h55;
    frame_end = 1'b1;
    #1;
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    wr = 1'b0;
    frame_end = 1'b0;
    chk({tag, "_init_cycles"}, n, 32);
    @(posedge clk);
    #1;
    chk_counts({tag, "_postinit"});
  endtask

  initial begin
    do_reset("init");

    // Single frame
    for (int i = 0; i < 8; i++) put_byte(8'h10 + 8'(i));
    end_frame();
    chk_counts("single");
    check_head("single");
    release_head();
    chk_counts("single_rel");

    // Overrun: 20 offered, 15 kept, then a clean frame
    for (int i = 0; i < 20; i++) put_byte(8'h40 + 8'(i));
    end_frame();
    for (int i = 0; i < 3; i++) put_byte(8'hc0 + 8'(i));
    end_frame();
    chk_counts("ovr");
    check_head("ovr1");
    release_head();
    check_head("ovr2");
    release_head();
    chk_counts("ovr_rel");

    // Empty frame_end is ignored
    end_frame();
    chk_counts("nullend");

    // Info full: 32 frames, then a dropped frame
    for (int i = 0; i < 32; i++) begin
      put_byte(8'(i * 3 + 1));
      end_frame();
    end
    for (int i = 0; i < 3; i++) put_byte(8'he0 + 8'(i));
    end_frame();
    chk_counts("full");
    check_head("full_h0");
    release_head();
    release_head();
    chk_counts("full_rel2");

    // Abort restores the committed byte count
    for (int i = 0; i < 5; i++) put_byte(8'h70 + 8'(i));
    chk_counts("abort_pend");
    abort_frame();
    chk_counts("abort");
    check_head("abort_h");

    // reset_mode mid-frame; wr and frame_end ignored meanwhile
    for (int i = 0; i < 3; i++) put_byte(8'h90 + 8'(i));
    reset_mode = 1'b1;
    wr = 1'b1;
    frame_end = 1'b1;
    tick();
    tick();
    reset_mode = 1'b0;
    wr = 1'b0;
    frame_end = 1'b0;
    model_clear(1'b0);
    chk_counts("rmode");
    put_byte(8'h5a);
    put_byte(8'ha5);
    end_frame();
    chk_counts("rmode_new");
    check_head("rmode_h");
    release_head();
    chk_counts("rmode_rel");

    // Reset mid-frame restarts init and clears drop_cnt
    put_byte(8'h33);
    do_reset("reinit");

    // Wrap with simultaneous release and write
    for (int i = 0; i < 8; i++) put_byte(8'ha0 + 8'(i));
    end_frame();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 15; i++) put_byte(8'(f * 16 + i));
      end_frame();
    end
    for (int i = 0; i < 7; i++) put_byte(8'hd0 + 8'(i));
    chk_counts("fill60");
    rel_and_write(8'hd7);
    chk_counts("relwr53");
    for (int i = 0; i < 6; i++) put_byte(8'hd8 + 8'(i));
    end_frame();
    chk_counts("wrap");
    for (int f = 0; f < 3; f++) begin
      check_head($sformatf("wrap_f%0d", f));
      release_head();
    end
    check_head("wrap_e");
    release_head();
    chk_counts("wrap_done");
    check_head("wrap_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
